// File: rtl/color_pkg.sv
// Shared color definitions for the nibble assembler and the color fader:
// channel widths, the fader state type and RGB slice helpers.
package color_pkg;

    localparam int CHAN_W  = 8;
    localparam int COLOR_W = 24;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fadeState_e;

    function automatic logic [CHAN_W-1:0] chanR(input logic [COLOR_W-1:0] color);
        return color[23:16];
    endfunction

    function automatic logic [CHAN_W-1:0] chanG(input logic [COLOR_W-1:0] color);
        return color[15:8];
    endfunction

    function automatic logic [CHAN_W-1:0] chanB(input logic [COLOR_W-1:0] color);
        return color[7:0];
    endfunction

endpackage

// File: rtl/color_fader_if.sv
// Signal bundle between the color assembler / top-level FSM and the color fader.
interface color_fader_if;
    import color_pkg::*;

    logic [COLOR_W-1:0] target_color;
    logic               load;
    logic [COLOR_W-1:0] current_color;
    logic               busy;
    logic               fade_done;
    logic               pwm_r;
    logic               pwm_g;
    logic               pwm_b;

    modport master (
        output target_color, load,
        input  current_color, busy, fade_done, pwm_r, pwm_g, pwm_b
    );

    modport slave (
        input  target_color, load,
        output current_color, busy, fade_done, pwm_r, pwm_g, pwm_b
    );

endinterface

// File: rtl/color_fader_fade_channel.sv
// One color channel of the fader: current/target registers, the one-LSB step
// toward the target, and the PWM compare against the shared counter.
module fade_channel
    import color_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [CHAN_W-1:0] target_i,
    input  logic              step_i,
    input  logic [CHAN_W-1:0] pwmCnt_i,
    output logic [CHAN_W-1:0] current_o,
    output logic              atTarget_o,
    output logic              pwm_o
);

    logic [CHAN_W-1:0] current_q, current_d;
    logic [CHAN_W-1:0] target_q, target_d;
    logic [CHAN_W-1:0] stepped;
    logic              pwm_q;

    always_comb begin
        stepped = current_q;
        if (current_q < target_q) begin
            stepped = current_q + CHAN_W'(1);
        end else if (current_q > target_q) begin
            stepped = current_q - CHAN_W'(1);
        end
        current_d = step_i ? stepped : current_q;
        target_d  = load_i ? target_i : target_q;
    end

    // Reports whether this channel lands on its target if the pending step is taken.
    assign atTarget_o = (stepped == target_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_q <= '0;
            target_q  <= '0;
            pwm_q     <= 1'b0;
        end else begin
            current_q <= current_d;
            target_q  <= target_d;
            pwm_q     <= (pwmCnt_i < current_q);
        end
    end

    assign current_o = current_q;
    assign pwm_o     = pwm_q;

endmodule

// File: rtl/color_fader.sv
// Color fader top: latches targets on load, ramps three channels one LSB per
// step, and drives registered PWM outputs from a shared free-running counter.
module color_fader
    import color_pkg::*;
#(
    parameter int STEP_DIV = 1024
) (
    input  logic          clk,
    input  logic          reset,
    color_fader_if.slave  bus
);

    localparam int TIMER_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [TIMER_W-1:0] TICK_LAST = TIMER_W'(STEP_DIV - 1);

    fadeState_e         state_q, state_d;
    logic [TIMER_W-1:0] stepTimer_q, stepTimer_d;
    logic               fadeDone_q, fadeDone_d;
    logic [CHAN_W-1:0]  pwmCnt_q;

    logic               stepTick;
    logic               doStep;
    logic [2:0]         chanAtTarget;
    logic [CHAN_W-1:0]  curR, curG, curB;
    logic [COLOR_W-1:0] currentColor;

    fade_channel uChanR (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bus.load),
        .target_i   (chanR(bus.target_color)),
        .step_i     (doStep),
        .pwmCnt_i   (pwmCnt_q),
        .current_o  (curR),
        .atTarget_o (chanAtTarget[2]),
        .pwm_o      (bus.pwm_r)
    );

    fade_channel uChanG (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bus.load),
        .target_i   (chanG(bus.target_color)),
        .step_i     (doStep),
        .pwmCnt_i   (pwmCnt_q),
        .current_o  (curG),
        .atTarget_o (chanAtTarget[1]),
        .pwm_o      (bus.pwm_g)
    );

    fade_channel uChanB (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bus.load),
        .target_i   (chanB(bus.target_color)),
        .step_i     (doStep),
        .pwmCnt_i   (pwmCnt_q),
        .current_o  (curB),
        .atTarget_o (chanAtTarget[0]),
        .pwm_o      (bus.pwm_b)
    );

    assign currentColor = {curR, curG, curB};
    assign stepTick     = (state_q == FADE) && (stepTimer_q == TICK_LAST);

    // A load restarts the step timer, so it pre-empts a coincident step tick.
    always_comb begin
        state_d     = state_q;
        stepTimer_d = '0;
        fadeDone_d  = 1'b0;
        doStep      = 1'b0;
        if (state_q == FADE && !stepTick) begin
            stepTimer_d = stepTimer_q + TIMER_W'(1);
        end
        if (bus.load) begin
            stepTimer_d = '0;
            if (bus.target_color == currentColor) begin
                state_d    = IDLE;
                fadeDone_d = 1'b1;
            end else begin
                state_d = FADE;
            end
        end else if (stepTick) begin
            doStep = 1'b1;
            if (&chanAtTarget) begin
                state_d    = IDLE;
                fadeDone_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            stepTimer_q <= '0;
            fadeDone_q  <= 1'b0;
            pwmCnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            stepTimer_q <= stepTimer_d;
            fadeDone_q  <= fadeDone_d;
            pwmCnt_q    <= pwmCnt_q + CHAN_W'(1);
        end
    end

    assign bus.current_color = currentColor;
    assign bus.busy          = (state_q == FADE);
    assign bus.fade_done     = fadeDone_q;

endmodule

// File: tb/tb_color_fader.sv
// Self-checking bench for color_fader: directed scenarios plus randomized loads,
// every cycle compared against a behavioural fade/PWM model.
module tb_color_fader;

    localparam int STEP_DIV = 4;

    logic clk;
    logic reset;

    color_fader_if bus ();

    color_fader #(.STEP_DIV(STEP_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecCount  = 0;
    int missCount = 0;
    int doneCount = 0;
    int busyCount = 0;

    int       mCur[3];
    int       mTgt[3];
    bit       mBusy;
    bit       mDone;
    bit       mRst;
    int       mWait;
    int       mCnt;
    bit [2:0] mPwm;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] modelColor();
        return {8'(mCur[0]), 8'(mCur[1]), 8'(mCur[2])};
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 3; c++) begin
            mCur[c] = 0;
            mTgt[c] = 0;
        end
        mBusy = 0;
        mDone = 0;
        mWait = 0;
        mCnt  = 0;
        mPwm  = '0;
    endtask

    // Behavioural view of one clock edge: PWM from pre-edge values, then load or fade progress.
    task automatic modelEdge(input bit ld, input logic [23:0] tc);
        bit allEq;
        if (mRst) begin
            modelReset();
            return;
        end
        for (int c = 0; c < 3; c++) mPwm[2-c] = (mCnt < mCur[c]);
        mCnt = (mCnt + 1) % 256;
        mDone = 0;
        if (ld) begin
            allEq = 1;
            for (int c = 0; c < 3; c++) begin
                mTgt[c] = (tc >> (16 - 8*c)) & 255;
                if (mTgt[c] != mCur[c]) allEq = 0;
            end
            mWait = 0;
            mBusy = !allEq;
            mDone = allEq;
        end else if (mBusy) begin
            mWait++;
            if (mWait == STEP_DIV) begin
                mWait = 0;
                allEq = 1;
                for (int c = 0; c < 3; c++) begin
                    if (mCur[c] < mTgt[c]) mCur[c]++;
                    else if (mCur[c] > mTgt[c]) mCur[c]--;
                    if (mCur[c] != mTgt[c]) allEq = 0;
                end
                if (allEq) begin
                    mBusy = 0;
                    mDone = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit ld, input logic [23:0] tc);
        bus.load         = ld;
        bus.target_color = tc;
        @(posedge clk);
        modelEdge(ld, tc);
        #1;
        checkOutput("current", 32'(bus.current_color), 32'(modelColor()));
        checkOutput("busy", 32'(bus.busy), 32'(mBusy));
        checkOutput("fade_done", 32'(bus.fade_done), 32'(mDone));
        checkOutput("pwm", 32'({bus.pwm_r, bus.pwm_g, bus.pwm_b}), 32'(mPwm));
        doneCount += int'(bus.fade_done);
        busyCount += int'(bus.busy);
        bus.load = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        int n = 0;
        while (bus.busy && n < maxCycles) begin
            applyStimulus(1'b0, 24'($urandom));
            n++;
        end
        checkOutput(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        int hiR, hiG, hiB;
        logic [23:0] tc;

        reset = 1'b0;
        bus.load = 1'b0;
        bus.target_color = '0;
        mRst = 1;
        modelReset();
        repeat (3) applyStimulus(1'b0, 24'h0);
        reset = 1'b1;
        mRst = 0;
        repeat (2) applyStimulus(1'b0, 24'h0);

        // Full ramp on red only.
        doneCount = 0;
        busyCount = 0;
        applyStimulus(1'b1, 24'hFF0000);
        repeat (STEP_DIV) applyStimulus(1'b0, 24'h0);
        checkOutput("rampFirstStep", 32'(bus.current_color), 32'h010000);
        waitIdle(1200, "rampIdle");
        checkOutput("rampColor", 32'(bus.current_color), 32'hFF0000);
        checkOutput("rampDoneCount", 32'(doneCount), 32'd1);
        checkOutput("rampBusyCycles", 32'(busyCount), 32'd1020);

        // Mixed directions: one step moves R down and B up.
        applyStimulus(1'b1, 24'h102030);
        waitIdle(1200, "mixPrepIdle");
        doneCount = 0;
        applyStimulus(1'b1, 24'h0F2031);
        repeat (STEP_DIV) applyStimulus(1'b0, 24'h0);
        checkOutput("mixColor", 32'(bus.current_color), 32'h0F2031);
        checkOutput("mixBusy", 32'(bus.busy), 32'd0);
        checkOutput("mixDoneCount", 32'(doneCount), 32'd1);

        // Retarget halfway through a ramp.
        applyStimulus(1'b1, 24'h000000);
        waitIdle(300, "retPrepIdle");
        doneCount = 0;
        applyStimulus(1'b1, 24'h0A0000);
        n = 0;
        while (bus.current_color[23:16] != 8'h05 && n < 100) begin
            applyStimulus(1'b0, 24'h0);
            n++;
        end
        checkOutput("retargetReach", 32'(bus.current_color[23:16]), 32'h05);
        applyStimulus(1'b1, 24'h000000);
        waitIdle(100, "retIdle");
        checkOutput("retColor", 32'(bus.current_color), 32'h0);
        checkOutput("retDoneCount", 32'(doneCount), 32'd1);

        // Load equal to the displayed color.
        applyStimulus(1'b1, 24'h123456);
        waitIdle(400, "eqPrepIdle");
        doneCount = 0;
        busyCount = 0;
        applyStimulus(1'b1, 24'h123456);
        checkOutput("eqDonePulse", 32'(bus.fade_done), 32'd1);
        repeat (3) applyStimulus(1'b0, 24'h0);
        checkOutput("eqDoneCount", 32'(doneCount), 32'd1);
        checkOutput("eqBusyCycles", 32'(busyCount), 32'd0);

        // PWM duty over one full period.
        applyStimulus(1'b1, 24'h0080FF);
        waitIdle(1200, "pwmPrepIdle");
        hiR = 0; hiG = 0; hiB = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 24'h0);
            hiR += int'(bus.pwm_r);
            hiG += int'(bus.pwm_g);
            hiB += int'(bus.pwm_b);
        end
        checkOutput("dutyR", 32'(hiR), 32'd0);
        checkOutput("dutyG", 32'(hiG), 32'd128);
        checkOutput("dutyB", 32'(hiB), 32'd255);

        // Asynchronous reset in the middle of a fade.
        applyStimulus(1'b1, 24'hFFFFFF);
        repeat (10) applyStimulus(1'b0, 24'h0);
        doneCount = 0;
        #3;
        reset = 1'b0;
        #1;
        checkOutput("rstColor", 32'(bus.current_color), 32'h0);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstDone", 32'(bus.fade_done), 32'd0);
        checkOutput("rstPwm", 32'({bus.pwm_r, bus.pwm_g, bus.pwm_b}), 32'd0);
        mRst = 1;
        modelReset();
        repeat (3) applyStimulus(1'b0, 24'h0);
        reset = 1'b1;
        mRst = 0;
        repeat (8) applyStimulus(1'b0, 24'h0);
        checkOutput("rstNoDone", 32'(doneCount), 32'd0);

        // Randomized loads near the current color, including mid-fade retargets.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                tc = modelColor();
            end else begin
                for (int c = 0; c < 3; c++) begin
                    int v;
                    v = mCur[c] + int'($urandom_range(0, 12)) - 6;
                    if (v < 0) v = 0;
                    if (v > 255) v = 255;
                    tc[23-8*c -: 8] = 8'(v);
                end
            end
            applyStimulus(1'b1, tc);
            n = int'($urandom_range(0, 30));
            for (int i = 0; i < n; i++) applyStimulus(1'b0, 24'($urandom));
        end
        waitIdle(100, "randIdle");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
